// File: rtl/bm_sequencer.sv
// rtl/bm_sequencer.sv - Symbol conditioning and branch-metric handshake sequencer
module bm_sequencer #(
  parameter int FRAME_LEN = 64,
  parameter bit SAT_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_r1,
  input  logic [7:0]  in_r2,
  input  logic [1:0]  in_erase,
  output logic [7:0]  bmu_r1,
  output logic [7:0]  bmu_r2,
  input  logic [7:0]  bmu_d1,
  input  logic [7:0]  bmu_d2,
  input  logic [7:0]  bmu_d3,
  input  logic [7:0]  bmu_d4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_d1,
  output logic [7:0]  out_d2,
  output logic [7:0]  out_d3,
  output logic [7:0]  out_d4,
  output logic        out_last,
  output logic [15:0] sym_count
);
  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_SETTLE = 3'd2,
    S_OUT    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_bmu_r1, r_bmu_r2;
  logic [7:0]  r_out_d1, r_out_d2, r_out_d3, r_out_d4;
  logic        r_out_last;
  logic [15:0] r_sym_count;
  logic        w_busy, w_in_ready, w_out_valid, w_frame_done;
  logic [7:0]  w_cond_r1, w_cond_r2;

  // Erase wins over everything; a zero magnitude is forced to +0 so the BMU never sees -0.
  function automatic logic [7:0] condition(input logic [7:0] sym, input logic erase);
    logic [6:0] mag;
    logic [7:0] res;
    mag = sym[6:0];
    if (SAT_EN && (mag > 7'd63)) mag = 7'h3F;
    res = {sym[7], mag};
    if (erase || (mag == 7'd0)) res = 8'h00;
    return res;
  endfunction

  assign w_cond_r1 = condition(in_r1, in_erase[0]);
  assign w_cond_r2 = condition(in_r2, in_erase[1]);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next_state = S_ACCEPT;
      S_ACCEPT: if (in_valid) w_next_state = S_SETTLE;
      S_SETTLE: w_next_state = S_OUT;
      S_OUT:    if (out_ready) w_next_state = r_out_last ? S_DONE : S_ACCEPT;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy       = (r_state != S_IDLE);
    w_in_ready   = (r_state == S_ACCEPT);
    w_out_valid  = (r_state == S_OUT);
    w_frame_done = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bmu_r1    <= 8'h00;
      r_bmu_r2    <= 8'h00;
      r_out_d1    <= 8'h00;
      r_out_d2    <= 8'h00;
      r_out_d3    <= 8'h00;
      r_out_d4    <= 8'h00;
      r_out_last  <= 1'b0;
      r_sym_count <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: if (start) r_sym_count <= 16'd0;
        S_ACCEPT: begin
          if (in_valid) begin
            r_bmu_r1 <= w_cond_r1;
            r_bmu_r2 <= w_cond_r2;
          end
        end
        S_SETTLE: begin
          r_out_d1   <= bmu_d1;
          r_out_d2   <= bmu_d2;
          r_out_d3   <= bmu_d3;
          r_out_d4   <= bmu_d4;
          r_out_last <= (r_sym_count == LAST_IDX);
        end
        S_OUT:  if (out_ready) r_sym_count <= r_sym_count + 16'd1;
        S_DONE: r_out_last <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy       = w_busy;
  assign in_ready   = w_in_ready;
  assign out_valid  = w_out_valid;
  assign frame_done = w_frame_done;
  assign bmu_r1     = r_bmu_r1;
  assign bmu_r2     = r_bmu_r2;
  assign out_d1     = r_out_d1;
  assign out_d2     = r_out_d2;
  assign out_d3     = r_out_d3;
  assign out_d4     = r_out_d4;
  assign out_last   = r_out_last;
  assign sym_count  = r_sym_count;
endmodule
